mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single SRAM-like memory bus between the fetch stage (instruction reads) and the commit stage (data loads/stores). It sits below fetch and commit, ahead of the bus bridge. It grants one requester at a time and latches that requester's command. It runs exactly one outstanding transaction through an address phase and a data phase. It returns a one-cycle `dataOK` pulse to the owner and silently drops instruction data that an exception or ERET flush has made stale.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_en`  in  1  fetch request; held high until `imem_dataOK`.
- `imem_addr`  in  ADDR_W  fetch address.
- `imem_rd`  out  DATA_W  fetch read data; valid when `imem_dataOK`.
- `imem_dataOK`  out  1  one-cycle fetch completion pulse.
- `dmem_en`  in  1  commit request; held high until `dmem_dataOK`.
- `dmem_wt`  in  1  1 = store, 0 = load.
- `dmem_size`  in  2  0 = byte, 1 = half, 2 = word.
- `dmem_addr`  in  ADDR_W  data address.
- `dmem_wd`  in  DATA_W  store data, already lane-formatted.
- `dmem_rd`  out  DATA_W  load data, raw bus word.
- `dmem_dataOK`  out  1  one-cycle commit completion pulse.
- `flush`  in  1  exception/ERET redirect from commit; kills the fetch side.
- `bus_req`  out  1  bus request.
- `bus_wr`  out  1  bus write.
- `bus_size`  out  2  bus size, same encoding as `dmem_size`.
- `bus_addr`  out  ADDR_W  bus address.
- `bus_wdata`  out  DATA_W  bus write data.
- `bus_addr_ok`  in  1  address accepted this cycle.
- `bus_data_ok`  in  1  data returned or write done this cycle.
- `bus_rdata`  in  DATA_W  bus read data.

## Operation
- FSM states: IDLE, ADDR, DATA.
- Registered state: `owner` (I/D), `last` (I/D), `discard`, and the latched command (`wr`, `size`, `addr`, `wdata`).
- Pending requests in IDLE:
  - `i_pend = imem_en & ~flush`.
  - `d_pend = dmem_en`.
- Grant rule in IDLE:
  - Only one pending: grant it.
  - Both pending: grant the side that is not `last` (round-robin).
  - On grant: latch the command (I side forces `wr=0`, `size=2`), set `owner`, set `last <= owner`, go to ADDR.
- ADDR:
  - `bus_req=1`; bus fields come from the latched command, never from live inputs.
  - `bus_addr_ok` moves the FSM to DATA and drops `bus_req` from the next cycle.
  - `bus_req` is never withdrawn before `addr_ok`, even on flush.
- DATA:
  - `bus_req=0`.
  - On `bus_data_ok`, pulse the owner's `dataOK` in the same cycle, unless `owner==I && discard`.
  - Then go to IDLE and clear `discard`.
- Read data: `imem_rd` and `dmem_rd` are combinational copies of `bus_rdata`. They are valid only in the `dataOK` cycle.
- Flush:
  - Sets `discard` when `owner==I` and state is ADDR or DATA.
  - In IDLE, flush masks `imem_en` for that cycle only.
  - Flush never affects a D transaction: commit has already resolved it.
- `flush` in the same cycle as `bus_data_ok` for an I transaction: the pulse is suppressed.
- `bus_data_ok` in IDLE or ADDR is ignored, because the bus guarantees data is returned no earlier than the cycle after `addr_ok`.
- The arbiter does no alignment or formatting; that is done in commit.

## Timing
- Reset values:
  - State IDLE, `last=I` (so the first tie goes to D), `discard=0`, `owner=I`.
  - All bus outputs 0.
  - `imem_dataOK=0`, `dmem_dataOK=0`.
- Request sampled in IDLE at cycle t: `bus_req` is high from t+1.
- Minimum latency: `addr_ok` at t+1 and `data_ok` at t+2 give `dataOK` at t+2, i.e. 2 cycles from `en` to `dataOK`.
- The cycle after `dataOK` is always IDLE. A requester still holding `en` there is a new request, so back-to-back transactions cost 3 cycles each at minimum.
- The FSM holds ADDR indefinitely while `addr_ok=0`, and holds DATA indefinitely while `data_ok=0`.
- Reset asserted mid-transaction: return to reset values immediately, with no `dataOK` pulse.

## Test plan
- D load, word at 0x8000_0010:
  - `dmem_en` at cycle 0, `addr_ok` at 1, `data_ok` at 2 with `bus_rdata=0x1234_5678`.
  - Required: `bus_req` high in cycle 1 only; `dmem_dataOK` pulses at 2 with `dmem_rd=0x1234_5678`; `imem_dataOK` stays 0.
- D store, byte (`size=0`, `wd=0xAAAA_AAAA`):
  - Required: `bus_wr=1`, `bus_size=0`, `bus_wdata=0xAAAA_AAAA` held constant while `addr_ok` is delayed 3 cycles; one `dmem_dataOK` pulse.
- Simultaneous `imem_en` and `dmem_en` out of reset, both held:
  - Required grant order D, I, D; each `dataOK` pulses once per transaction.
- I fetch with `flush` asserted in DATA at 0xBFC0_0000:
  - `data_ok` arrives.
  - Required: no `imem_dataOK`; FSM returns to IDLE; the next fetch completes normally.
- `flush` in IDLE with `imem_en` and `dmem_en` both high:
  - Required: D is granted and completes; I is granted only after flush drops.
- `reset` pulsed low while in DATA:
  - Required: all outputs 0 immediately; a stray `bus_data_ok` afterwards yields no `dataOK` pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/commit arbiter for the shared SRAM-like memory bus
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   imem_*              fetch side: en/addr in, rd/dataOK out (reads only)
//   dmem_*              commit side: en/wt/size/addr/wd in, rd/dataOK out
//   flush               exception/ERET redirect; kills the in-flight fetch
//   bus_*               single-outstanding address/data phase memory bus
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_en,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_rd,
    output logic              imem_dataOK,
    input  logic              dmem_en,
    input  logic              dmem_wt,
    input  logic [1:0]        dmem_size,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wd,
    output logic [DATA_W-1:0] dmem_rd,
    output logic              dmem_dataOK,
    input  logic              flush,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_t            state;
    state_t            state_nx;
    logic              owner;
    logic              last;
    logic              discard;
    logic              cmd_wr;
    logic [1:0]        cmd_size;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              i_pend;
    logic              d_pend;
    logic              grant;
    logic              grant_side;
    logic              done;

    always_comb begin
        i_pend     = imem_en & ~flush;
        d_pend     = dmem_en;
        grant      = 1'b0;
        grant_side = SIDE_I;
        state_nx   = state;
        case (state)
            IDLE: begin
                if (i_pend | d_pend) begin
                    grant = 1'b1;
                    // On a tie the side that did not win last time goes first.
                    if (i_pend & d_pend) begin
                        grant_side = ~last;
                    end else begin
                        grant_side = d_pend;
                    end
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= SIDE_I;
            last      <= SIDE_I;
            discard   <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_size  <= 2'd0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                owner     <= grant_side;
                last      <= grant_side;
                discard   <= 1'b0;
                cmd_wr    <= (grant_side == SIDE_D) ? dmem_wt : 1'b0;
                cmd_size  <= (grant_side == SIDE_D) ? dmem_size : 2'd2;
                cmd_addr  <= (grant_side == SIDE_D) ? dmem_addr : imem_addr;
                cmd_wdata <= (grant_side == SIDE_D) ? dmem_wd : '0;
            end else if (state == DATA && bus_data_ok) begin
                discard <= 1'b0;
            end else if ((state == ADDR || state == DATA) && owner == SIDE_I && flush) begin
                // The bus request cannot be withdrawn, so a killed fetch
                // runs to completion and its data is dropped.
                discard <= 1'b1;
            end
        end
    end

    assign bus_req   = (state == ADDR);
    assign bus_wr    = cmd_wr;
    assign bus_size  = cmd_size;
    assign bus_addr  = cmd_addr;
    assign bus_wdata = cmd_wdata;

    // bus_data_ok outside DATA cannot belong to our transaction.
    assign done        = (state == DATA) & bus_data_ok;
    assign imem_dataOK = done & (owner == SIDE_I) & ~discard & ~flush;
    assign dmem_dataOK = done & (owner == SIDE_D);

    assign imem_rd = bus_rdata;
    assign dmem_rd = bus_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        imem_dataOK;
    logic        dmem_en;
    logic        dmem_wt;
    logic [1:0]  dmem_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wd;
    logic [31:0] dmem_rd;
    logic        dmem_dataOK;
    logic        flush;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int total;
    int bad;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_dataOK (imem_dataOK),
        .dmem_en     (dmem_en),
        .dmem_wt     (dmem_wt),
        .dmem_size   (dmem_size),
        .dmem_addr   (dmem_addr),
        .dmem_wd     (dmem_wd),
        .dmem_rd     (dmem_rd),
        .dmem_dataOK (dmem_dataOK),
        .flush       (flush),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One arbitration: IDLE (grant), ADDR (addr_ok at once), DATA (data_ok at once).
    task automatic xact(input logic exp_d, input logic [31:0] exp_addr, input logic fl);
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        flush       = fl;
        #1;
        check("xact_idle_req", bus_req, 0);
        tick();
        flush       = 1'b0;
        bus_addr_ok = 1'b1;
        #1;
        check("xact_addr_req", bus_req, 1);
        check("xact_addr", bus_addr, exp_addr);
        check("xact_wr", bus_wr, 0);
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = exp_addr ^ 32'hFFFF_0000;
        #1;
        check("xact_data_req", bus_req, 0);
        check("xact_dmem_ok", dmem_dataOK, exp_d);
        check("xact_imem_ok", imem_dataOK, !exp_d);
        check("xact_rd", exp_d ? dmem_rd : imem_rd, exp_addr ^ 32'hFFFF_0000);
        tick();
        bus_data_ok = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        imem_en     = 1'b0;
        imem_addr   = '0;
        dmem_en     = 1'b0;
        dmem_wt     = 1'b0;
        dmem_size   = 2'd0;
        dmem_addr   = '0;
        dmem_wd     = '0;
        flush       = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = '0;
        #1 reset = 1'b0;
        #1;
        check("rst_req", bus_req, 0);
        check("rst_wr", bus_wr, 0);
        check("rst_size", bus_size, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_iok", imem_dataOK, 0);
        check("rst_dok", dmem_dataOK, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // D load word at 0x8000_0010, minimum latency
        dmem_en   = 1'b1;
        dmem_wt   = 1'b0;
        dmem_size = 2'd2;
        dmem_addr = 32'h8000_0010;
        #1;
        check("ld_c0_req", bus_req, 0);
        tick();
        bus_addr_ok = 1'b1;
        #1;
        check("ld_c1_req", bus_req, 1);
        check("ld_c1_addr", bus_addr, 32'h8000_0010);
        check("ld_c1_wr", bus_wr, 0);
        check("ld_c1_size", bus_size, 2);
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h1234_5678;
        #1;
        check("ld_c2_req", bus_req, 0);
        check("ld_c2_dok", dmem_dataOK, 1);
        check("ld_c2_rd", dmem_rd, 32'h1234_5678);
        check("ld_c2_iok", imem_dataOK, 0);
        tick();
        dmem_en     = 1'b0;
        bus_data_ok = 1'b0;
        #1;
        check("ld_c3_req", bus_req, 0);
        check("ld_c3_dok", dmem_dataOK, 0);
        tick();

        // D store byte, addr_ok delayed 3 cycles; live inputs change meanwhile
        dmem_en   = 1'b1;
        dmem_wt   = 1'b1;
        dmem_size = 2'd0;
        dmem_addr = 32'h0000_0100;
        dmem_wd   = 32'hAAAA_AAAA;
        #1;
        tick();
        dmem_wd   = 32'h5555_5555;
        dmem_size = 2'd2;
        dmem_wt   = 1'b0;
        dmem_addr = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_wait_req", bus_req, 1);
            check("st_wait_wr", bus_wr, 1);
            check("st_wait_size", bus_size, 0);
            check("st_wait_wdata", bus_wdata, 32'hAAAA_AAAA);
            check("st_wait_addr", bus_addr, 32'h0000_0100);
            check("st_wait_dok", dmem_dataOK, 0);
            tick();
        end
        bus_addr_ok = 1'b1;
        #1;
        check("st_aok_req", bus_req, 1);
        check("st_aok_wdata", bus_wdata, 32'hAAAA_AAAA);
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        #1;
        check("st_dok", dmem_dataOK, 1);
        check("st_iok", imem_dataOK, 0);
        tick();
        dmem_en     = 1'b0;
        bus_data_ok = 1'b0;
        #1;
        check("st_after_dok", dmem_dataOK, 0);
        check("st_after_req", bus_req, 0);
        tick();

        // Both requesters out of reset: D, I, D; then flush in IDLE masks I
        reset = 1'b0;
        #1;
        reset     = 1'b1;
        imem_addr = 32'h0000_1000;
        dmem_addr = 32'h0000_2000;
        dmem_wt   = 1'b0;
        dmem_size = 2'd2;
        imem_en   = 1'b1;
        dmem_en   = 1'b1;
        xact(1'b1, 32'h0000_2000, 1'b0);
        xact(1'b0, 32'h0000_1000, 1'b0);
        xact(1'b1, 32'h0000_2000, 1'b0);
        xact(1'b1, 32'h0000_2000, 1'b1);
        xact(1'b0, 32'h0000_1000, 1'b0);
        imem_en = 1'b0;
        dmem_en = 1'b0;
        #1;
        check("rr_end_req", bus_req, 0);
        tick();

        // I fetch killed by flush in DATA
        imem_en   = 1'b1;
        imem_addr = 32'hBFC0_0000;
        #1;
        tick();
        bus_addr_ok = 1'b1;
        #1;
        check("fl_addr", bus_addr, 32'hBFC0_0000);
        check("fl_size", bus_size, 2);
        check("fl_wr", bus_wr, 0);
        tick();
        bus_addr_ok = 1'b0;
        flush       = 1'b1;
        #1;
        check("fl_flush_iok", imem_dataOK, 0);
        tick();
        flush       = 1'b0;
        bus_data_ok = 1'b1;
        #1;
        check("fl_drop_iok", imem_dataOK, 0);
        check("fl_drop_dok", dmem_dataOK, 0);
        tick();
        imem_addr = 32'hBFC0_0004;
        xact(1'b0, 32'hBFC0_0004, 1'b0);

        // flush in the same cycle as data_ok suppresses the fetch pulse
        #1;
        tick();
        bus_addr_ok = 1'b1;
        #1;
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        flush       = 1'b1;
        #1;
        check("fl_same_iok", imem_dataOK, 0);
        tick();
        flush       = 1'b0;
        bus_data_ok = 1'b0;
        imem_en     = 1'b0;
        #1;
        check("fl_same_idle", bus_req, 0);
        tick();

        // reset pulsed while in DATA of a store
        dmem_en   = 1'b1;
        dmem_wt   = 1'b1;
        dmem_size = 2'd1;
        dmem_addr = 32'h0000_0300;
        dmem_wd   = 32'hCAFE_BABE;
        #1;
        tick();
        bus_addr_ok = 1'b1;
        #1;
        check("rd_pre_req", bus_req, 1);
        check("rd_pre_wdata", bus_wdata, 32'hCAFE_BABE);
        tick();
        bus_addr_ok = 1'b0;
        #1;
        reset   = 1'b0;
        dmem_en = 1'b0;
        #1;
        check("rd_req", bus_req, 0);
        check("rd_wr", bus_wr, 0);
        check("rd_size", bus_size, 0);
        check("rd_addr", bus_addr, 0);
        check("rd_wdata", bus_wdata, 0);
        bus_data_ok = 1'b1;
        #1;
        check("rd_in_dok", dmem_dataOK, 0);
        check("rd_in_iok", imem_dataOK, 0);
        tick();
        reset = 1'b1;
        #1;
        check("rd_stray_dok", dmem_dataOK, 0);
        check("rd_stray_iok", imem_dataOK, 0);
        check("rd_stray_req", bus_req, 0);
        tick();
        bus_data_ok = 1'b0;
        #1;
        check("rd_final_req", bus_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
